// File: rtl/poly1305_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the Poly1305 core.
package poly1305_pkg;

    localparam int LIMB_W  = 32;
    localparam int H_LIMBS = 5;
    localparam int R_LIMBS = 4;
    localparam int N_PROD  = H_LIMBS * R_LIMBS;
    localparam int H_W     = 132;   // accumulator: partial reduction < 2^131, plus one block
    localparam int PROD_W  = 260;
    localparam int BLK_W   = 128;
    localparam int BYTES_W = 5;

    localparam logic [127:0] CLAMP   = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
    localparam int unsigned  P_MINUS = 5;    // p = 2^130 - P_MINUS

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_BLK,
        ST_ADD,
        ST_MUL,
        ST_RED1,
        ST_RED2,
        ST_FIN1,
        ST_FIN2,
        ST_FIN3,
        ST_DONE
    } state_e;

    // Cycles needed to issue all 20 limb products at the given lane count.
    function automatic int mul_cycles(input int lanes);
        return (N_PROD + lanes - 1) / lanes;
    endfunction

    // One folding step: bits >= 130 are worth P_MINUS times their value mod p.
    // Callers guarantee the result fits in H_W bits.
    function automatic logic [H_W-1:0] fold130(input logic [PROD_W-1:0] x);
        return H_W'(x[129:0]) + H_W'({130'b0, x[PROD_W-1:130]} * PROD_W'(P_MINUS));
    endfunction

endpackage

// File: rtl/poly1305_mac_core_if.sv
// Message-block stream between the AEAD framer (master) and the MAC core (slave).
interface poly1305_mac_core_if;
    import poly1305_pkg::*;

    logic               i_blk_valid;
    logic               o_blk_ready;
    logic [BLK_W-1:0]   i_blk_data;
    logic [BYTES_W-1:0] i_blk_bytes;
    logic               i_blk_last;

    modport master (
        output i_blk_valid, i_blk_data, i_blk_bytes, i_blk_last,
        input  o_blk_ready
    );

    modport slave (
        input  i_blk_valid, i_blk_data, i_blk_bytes, i_blk_last,
        output o_blk_ready
    );
endinterface

// File: rtl/poly1305_mul_lanes.sv
// Time-multiplexed h*r multiplier: MUL_LANES 32x32 limb products per cycle,
// each shifted to its column and summed into a 260-bit accumulator.
module poly1305_mul_lanes
    import poly1305_pkg::*;
#(
    parameter int MUL_LANES = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_start,
    input  logic                       i_clr,
    input  logic [H_LIMBS*LIMB_W-1:0]  i_a,
    input  logic [R_LIMBS*LIMB_W-1:0]  i_b,
    output logic                       o_done,
    output logic [PROD_W-1:0]          o_prod
);
    localparam int NCYC  = mul_cycles(MUL_LANES);
    localparam int CYC_W = 5;

    logic [CYC_W-1:0]  cyc_q;
    logic              run_q;
    logic [PROD_W-1:0] acc_q;
    logic [PROD_W-1:0] part_s;

    // Sum of this cycle's lane products, each placed at column 32*(i+j).
    always_comb begin
        int          k;
        logic [63:0] lp;
        part_s = '0;
        k      = 0;
        lp     = 64'h0;
        for (int l = 0; l < MUL_LANES; l++) begin
            k = int'(cyc_q) * MUL_LANES + l;
            if (k < N_PROD) begin
                lp     = {32'h0, i_a[(k / R_LIMBS) * LIMB_W +: LIMB_W]}
                       * {32'h0, i_b[(k % R_LIMBS) * LIMB_W +: LIMB_W]};
                part_s = part_s + ({196'b0, lp} << (LIMB_W * ((k / R_LIMBS) + (k % R_LIMBS))));
            end else begin
                part_s = part_s;
            end
        end
    end

    // Product schedule: start clears, each running cycle adds one lane group.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cyc_q <= '0;
            run_q <= 1'b0;
            acc_q <= '0;
        end else if (i_clr) begin
            cyc_q <= '0;
            run_q <= 1'b0;
            acc_q <= '0;
        end else if (i_start) begin
            cyc_q <= '0;
            run_q <= 1'b1;
            acc_q <= '0;
        end else if (run_q) begin
            acc_q <= acc_q + part_s;
            cyc_q <= cyc_q + CYC_W'(1);
            run_q <= (cyc_q != CYC_W'(NCYC - 1));
        end else begin
            acc_q <= acc_q;
        end
    end

    assign o_done = run_q && (cyc_q == CYC_W'(NCYC - 1));
    assign o_prod = acc_q;

endmodule

// File: rtl/poly1305_mac_core.sv
// Poly1305 one-time authenticator: block absorb (add, multiply, partial
// reduction), final reduction mod 2^130-5, tag = h + s, optional on-chip verify.
module poly1305_mac_core
    import poly1305_pkg::*;
#(
    parameter int MUL_LANES = 4,
    parameter int CNT_W     = 32
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_start,
    input  logic [127:0]       i_key_r,
    input  logic [127:0]       i_key_s,
    input  logic               i_verify,
    input  logic [127:0]       i_exp_tag,
    poly1305_mac_core_if.slave blk,
    input  logic               i_abort,
    output logic               o_busy,
    output logic [CNT_W-1:0]   o_blk_cnt,
    output logic [127:0]       o_tag,
    output logic               o_tag_valid,
    output logic               o_tag_ok
);
    state_e             state_q, state_d;
    logic [127:0]       r_q, r_d, s_q, s_d, exp_q, exp_d, tag_q, tag_d;
    logic [BLK_W-1:0]   data_q, data_d;
    logic [BYTES_W-1:0] nb_q, nb_d;
    logic               verify_q, verify_d, ok_q, ok_d, last_q, last_d;
    logic [H_W-1:0]     h_q, h_d, g_s;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [128:0]       msg_s;
    logic               mul_start_s, mul_done_s;
    logic [PROD_W-1:0]  prod_s;

    poly1305_mul_lanes #(.MUL_LANES(MUL_LANES)) u_mul (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_start (mul_start_s),
        .i_clr   (i_abort),
        .i_a     ({28'b0, h_q}),
        .i_b     (r_q),
        .o_done  (mul_done_s),
        .o_prod  (prod_s)
    );

    // Padded block value: valid bytes, a 0x01 byte just above them, zeros elsewhere.
    always_comb begin
        msg_s = '0;
        for (int b = 0; b < 16; b++) begin
            if (b < int'(nb_q)) begin
                msg_s[8*b +: 8] = data_q[8*b +: 8];
            end else begin
                msg_s[8*b +: 8] = 8'h00;
            end
        end
        msg_s[{nb_q, 3'b000}] = 1'b1;
    end

    assign g_s = h_q + H_W'(P_MINUS);

    // Next-state and datapath: abort overrides everything, otherwise walk the FSM.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        s_d         = s_q;
        exp_d       = exp_q;
        verify_d    = verify_q;
        h_d         = h_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        nb_d        = nb_q;
        last_d      = last_q;
        tag_d       = tag_q;
        ok_d        = ok_q;
        mul_start_s = 1'b0;
        if (i_abort) begin
            state_d  = ST_IDLE;
            r_d      = '0;
            s_d      = '0;
            exp_d    = '0;
            verify_d = 1'b0;
            h_d      = '0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_d  = ST_WAIT_BLK;
                        r_d      = i_key_r & CLAMP;
                        s_d      = i_key_s;
                        verify_d = i_verify;
                        exp_d    = i_exp_tag;
                        h_d      = '0;
                        cnt_d    = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT_BLK: begin
                    if (blk.i_blk_valid) begin
                        state_d = ST_ADD;
                        data_d  = blk.i_blk_data;
                        nb_d    = (blk.i_blk_bytes > 5'd16) ? 5'd16 : blk.i_blk_bytes;
                        last_d  = blk.i_blk_last;
                    end else begin
                        state_d = ST_WAIT_BLK;
                    end
                end
                ST_ADD: begin
                    if (nb_q == 5'd0) begin
                        state_d = last_q ? ST_FIN1 : ST_WAIT_BLK;
                    end else begin
                        h_d         = h_q + {3'b0, msg_s};
                        mul_start_s = 1'b1;
                        state_d     = ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (mul_done_s) begin
                        state_d = ST_RED1;
                    end else begin
                        state_d = ST_MUL;
                    end
                end
                ST_RED1: begin
                    h_d     = fold130(prod_s);
                    state_d = ST_RED2;
                end
                ST_RED2: begin
                    h_d     = fold130({128'b0, h_q});
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = last_q ? ST_FIN1 : ST_WAIT_BLK;
                end
                ST_FIN1: begin
                    // Brings h below 2^130 + 15, so one conditional subtract of p suffices.
                    h_d     = fold130({128'b0, h_q});
                    state_d = ST_FIN2;
                end
                ST_FIN2: begin
                    if (g_s[H_W-1:130] != 2'b00) begin
                        h_d = {2'b00, g_s[129:0]};
                    end else begin
                        h_d = h_q;
                    end
                    state_d = ST_FIN3;
                end
                ST_FIN3: begin
                    tag_d   = h_q[127:0] + s_q;
                    ok_d    = !verify_q || (tag_d == exp_q);
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    // Scrub key material once the tag is out.
                    r_d      = '0;
                    s_d      = '0;
                    exp_d    = '0;
                    verify_d = 1'b0;
                    h_d      = '0;
                    state_d  = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= ST_IDLE;
            r_q      <= '0;
            s_q      <= '0;
            exp_q    <= '0;
            verify_q <= 1'b0;
            h_q      <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            nb_q     <= '0;
            last_q   <= 1'b0;
            tag_q    <= '0;
            ok_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            s_q      <= s_d;
            exp_q    <= exp_d;
            verify_q <= verify_d;
            h_q      <= h_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            nb_q     <= nb_d;
            last_q   <= last_d;
            tag_q    <= tag_d;
            ok_q     <= ok_d;
        end
    end

    assign blk.o_blk_ready = (state_q == ST_WAIT_BLK);
    assign o_busy          = (state_q != ST_IDLE);
    assign o_tag_valid     = (state_q == ST_DONE);
    assign o_blk_cnt       = cnt_q;
    assign o_tag           = tag_q;
    assign o_tag_ok        = ok_q;

endmodule

// File: tb/tb_poly1305_mac_core.sv
// Directed bench: three cores (1, 4 and 20 lanes) on shared key/data inputs,
// RFC 8439 vectors, verify mode, empty message, abort and ignored restart.
module tb_poly1305_mac_core;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] key_r, key_s, exp_tag, blk_data;
    logic         verify, blk_last, abort;
    logic [4:0]   blk_bytes;
    logic [ND-1:0] start_v, valid_v, ready_v, busy_v, tv_v, ok_v;
    logic [127:0] tag_v [ND];
    logic [31:0]  cnt_v [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int LN = (g == 0) ? 1 : ((g == 1) ? 4 : 20);
        poly1305_mac_core_if bif ();
        assign bif.i_blk_valid = valid_v[g];
        assign bif.i_blk_data  = blk_data;
        assign bif.i_blk_bytes = blk_bytes;
        assign bif.i_blk_last  = blk_last;
        assign ready_v[g]      = bif.o_blk_ready;
        poly1305_mac_core #(.MUL_LANES(LN), .CNT_W(32)) u_dut (
            .i_clk       (clk),
            .i_rstn      (rstn),
            .i_start     (start_v[g]),
            .i_key_r     (key_r),
            .i_key_s     (key_s),
            .i_verify    (verify),
            .i_exp_tag   (exp_tag),
            .blk         (bif),
            .i_abort     (abort),
            .o_busy      (busy_v[g]),
            .o_blk_cnt   (cnt_v[g]),
            .o_tag       (tag_v[g]),
            .o_tag_valid (tv_v[g]),
            .o_tag_ok    (ok_v[g])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [127:0] tag;
        logic         ok;
        int           cnt;
    } exp_t;
    exp_t sb[$];
    byte unsigned msg[$];

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    function automatic int lblk(input int d);
        int ln;
        ln = (d == 0) ? 1 : ((d == 1) ? 4 : 20);
        return 3 + (20 + ln - 1) / ln;
    endfunction

    // Hex written in RFC byte order -> little-endian vector (byte0 at [7:0]).
    function automatic logic [127:0] bswap(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
        return y;
    endfunction

    task automatic run_msg(input int d, input logic [127:0] r, input logic [127:0] s,
                           input logic ver, input logic [127:0] et,
                           input logic [127:0] xtag, input logic xok, input logic mid_start);
        int nbytes, nblk, hs, wt, nb;
        exp_t e;
        logic [127:0] data;
        nbytes = msg.size();
        nblk   = (nbytes == 0) ? 1 : (nbytes + 15) / 16;
        e.tag  = xtag;
        e.ok   = xok;
        e.cnt  = (nbytes + 15) / 16;
        sb.push_back(e);
        key_r = r; key_s = s; verify = ver; exp_tag = et;
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
        check("busy_after_start", 128'(busy_v[d]), 128'h1);
        check("cnt_cleared", 128'(cnt_v[d]), 128'h0);
        hs = 0;
        for (int k = 0; k < nblk; k++) begin
            data = '0;
            for (int b = 0; b < 16; b++) begin
                if (16*k + b < nbytes) data[8*b +: 8] = msg[16*k + b];
            end
            nb = nbytes - 16*k;
            if (nb > 16) nb = 16;
            blk_data   = data;
            blk_bytes  = 5'(nb);
            blk_last   = (k == nblk - 1);
            valid_v[d] = 1'b1;
            wt = 0;
            while (!ready_v[d] && wt < 200) begin
                @(negedge clk);
                wt++;
            end
            check("ready_seen", 128'(ready_v[d]), 128'h1);
            if (k > 0) check("blk_latency", 128'(cyc - hs), 128'(lblk(d)));
            hs = cyc + 1;
            @(negedge clk);
            check("ready_drops_after_hs", 128'(ready_v[d]), 128'h0);
            if (mid_start && k == 0) begin
                key_r = ~r; key_s = ~s;
                start_v[d] = 1'b1;
                @(negedge clk);
                start_v[d] = 1'b0;
                key_r = r; key_s = s;
            end
        end
        valid_v[d] = 1'b0;
        wt = 0;
        while (!tv_v[d] && wt < 200) begin
            @(negedge clk);
            wt++;
        end
        check("tag_valid_seen", 128'(tv_v[d]), 128'h1);
        check("tag_latency", 128'(cyc - hs), 128'((nbytes == 0) ? 4 : lblk(d) + 3));
        e = sb.pop_front();
        check("tag", tag_v[d], e.tag);
        check("tag_ok", 128'(ok_v[d]), 128'(e.ok));
        check("blk_cnt", 128'(cnt_v[d]), 128'(e.cnt));
        @(negedge clk);
        check("tag_valid_pulse", 128'(tv_v[d]), 128'h0);
        check("busy_clear", 128'(busy_v[d]), 128'h0);
        check("tag_held", tag_v[d], e.tag);
    endtask

    task automatic load_vec1();
        string str;
        str = "Cryptographic Forum Research Group";
        msg.delete();
        for (int i = 0; i < str.len(); i++) msg.push_back(str[i]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] r1, s1, t1, tmp, prev;
        int seen;
        tmp = 128'h85d6be7857556d337f4452fe42d506a8; r1 = bswap(tmp);
        tmp = 128'h0103808afb0db2fd4abff6af4149f51b; s1 = bswap(tmp);
        tmp = 128'ha8061dc1305136c6c22b8baf0c0127a9; t1 = bswap(tmp);

        rstn = 1'b0; key_r = '0; key_s = '0; exp_tag = '0; blk_data = '0;
        verify = 1'b0; blk_last = 1'b0; abort = 1'b0; blk_bytes = 5'd0;
        start_v = '0; valid_v = '0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check("rst_tag", tag_v[d], 128'h0);
            check("rst_tag_valid", 128'(tv_v[d]), 128'h0);
            check("rst_busy", 128'(busy_v[d]), 128'h0);
            check("rst_ready", 128'(ready_v[d]), 128'h0);
            check("rst_cnt", 128'(cnt_v[d]), 128'h0);
            check("rst_ok", 128'(ok_v[d]), 128'h0);
        end

        // Block offered while idle is not accepted.
        valid_v[1] = 1'b1;
        @(negedge clk);
        check("idle_no_ready", 128'(ready_v[1]), 128'h0);
        check("idle_no_busy", 128'(busy_v[1]), 128'h0);
        valid_v[1] = 1'b0;

        // RFC 8439 2.5.2 at 1, 4 and 20 lanes; restart mid-message on the 4-lane core.
        load_vec1();
        run_msg(0, r1, s1, 1'b0, 128'h0, t1, 1'b1, 1'b0);
        run_msg(1, r1, s1, 1'b0, 128'h0, t1, 1'b1, 1'b1);
        run_msg(2, r1, s1, 1'b0, 128'h0, t1, 1'b1, 1'b0);

        // Verify mode: correct and bit-0-flipped expected tag.
        run_msg(1, r1, s1, 1'b1, t1, t1, 1'b1, 1'b0);
        run_msg(1, r1, s1, 1'b1, t1 ^ 128'h1, t1, 1'b0, 1'b0);

        // Wrap-around: h*r lands in [p, 2^130) and needs the final subtract.
        msg.delete();
        for (int i = 0; i < 16; i++) msg.push_back(8'hff);
        run_msg(1, 128'h2, 128'h0, 1'b0, 128'h0, 128'h3, 1'b1, 1'b0);
        run_msg(2, 128'h2, 128'h0, 1'b0, 128'h0, 128'h3, 1'b1, 1'b0);

        // Empty message: tag is s.
        msg.delete();
        run_msg(1, r1, 128'h000102030405060708090a0b0c0d0e0f, 1'b0, 128'h0,
                128'h000102030405060708090a0b0c0d0e0f, 1'b1, 1'b0);

        // Abort during MUL.
        prev = tag_v[1];
        key_r = r1; key_s = s1; verify = 1'b0;
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        load_vec1();
        blk_data = '0;
        for (int b = 0; b < 16; b++) blk_data[8*b +: 8] = msg[b];
        blk_bytes = 5'd16; blk_last = 1'b0; valid_v[1] = 1'b1;
        @(negedge clk);
        valid_v[1] = 1'b0;
        @(negedge clk);
        check("busy_in_mul", 128'(busy_v[1]), 128'h1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 128'(busy_v[1]), 128'h0);
        check("abort_cnt", 128'(cnt_v[1]), 128'h0);
        check("abort_ready", 128'(ready_v[1]), 128'h0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tv_v[1]) seen++;
        end
        check("abort_no_tag_valid", 128'(seen), 128'h0);
        check("abort_tag_kept", tag_v[1], prev);

        // Abort coincident with start: nothing captured.
        start_v[1] = 1'b1; abort = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0; abort = 1'b0;
        check("abort_with_start", 128'(busy_v[1]), 128'h0);

        // Restart after abort.
        run_msg(1, r1, s1, 1'b0, 128'h0, t1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
